// File: rtl/kart_nav_if.sv
// Erase/draw request bundle between the navigation controller and the VGA drawing stage.
// The controller holds a request stable until it samples draw_ack high.
interface kart_nav_if #(
   parameter int XW = 8,
   parameter int YW = 7
);
   logic          draw_req;
   logic          draw_erase;
   logic [XW-1:0] draw_x;
   logic [YW-1:0] draw_y;
   logic          draw_ack;

   modport master (
      output draw_req, draw_erase, draw_x, draw_y,
      input  draw_ack
   );

   modport slave (
      input  draw_req, draw_erase, draw_x, draw_y,
      output draw_ack
   );
endinterface

// File: rtl/kart_nav_ctrl.sv
// Kart navigation: turns direction-input edges into heading changes and clamped grid moves,
// and issues an erase/draw request pair for each move.
//
// state    | meaning
// ST_IDLE  | waiting for a pending command; turns and wall hits resolve here
// ST_ERASE | requesting erase of the old cell
// ST_MOVE  | one-cycle position update to the target cell
// ST_DRAW  | requesting paint of the new cell
module kart_nav_ctrl #(
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119,
   parameter int X_START = 80,
   parameter int Y_START = 60,
   parameter int XW      = 8,
   parameter int YW      = 7
) (
   input  logic          CLOCK_50,
   input  logic          Resetn,
   input  logic          signalStraight,
   input  logic          signalLeft,
   input  logic          signalRight,
   kart_nav_if.master    draw_bus,
   output logic [XW-1:0] pos_x,
   output logic [YW-1:0] pos_y,
   output logic [1:0]    heading,
   output logic          busy,
   output logic          blocked
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ERASE = 2'd1;
   localparam logic [1:0] ST_MOVE  = 2'd2;
   localparam logic [1:0] ST_DRAW  = 2'd3;

   localparam logic [1:0] CMD_FWD   = 2'd0;
   localparam logic [1:0] CMD_LEFT  = 2'd1;
   localparam logic [1:0] CMD_RIGHT = 2'd2;

   localparam logic [1:0] HD_N = 2'd0;
   localparam logic [1:0] HD_E = 2'd1;
   localparam logic [1:0] HD_S = 2'd2;
   localparam logic [1:0] HD_W = 2'd3;

   localparam logic [XW-1:0] X_LIM  = XW'(X_MAX);
   localparam logic [YW-1:0] Y_LIM  = YW'(Y_MAX);
   localparam logic [XW-1:0] X_INIT = XW'(X_START);
   localparam logic [YW-1:0] Y_INIT = YW'(Y_START);

   logic [1:0]    state;
   logic [2:0]    prev;
   logic [2:0]    in_edge;
   logic          pend_v;
   logic [1:0]    pend_cmd;
   logic [1:0]    edge_cmd;
   logic          consume;
   logic          at_wall;
   logic [XW-1:0] tgt_x;
   logic [YW-1:0] tgt_y;

   // bit 2 = straight, bit 1 = left, bit 0 = right
   assign in_edge = {signalStraight, signalLeft, signalRight} & ~prev;
   assign consume = pend_v && (state == ST_IDLE);

   always_comb begin
      edge_cmd = CMD_RIGHT;
      if (in_edge[2])      edge_cmd = CMD_FWD;
      else if (in_edge[1]) edge_cmd = CMD_LEFT;
   end

   always_comb begin
      at_wall = 1'b0;
      tgt_x   = pos_x;
      tgt_y   = pos_y;
      case (heading)
         HD_N: begin at_wall = (pos_y == '0);    tgt_y = pos_y - 1'b1; end
         HD_E: begin at_wall = (pos_x == X_LIM); tgt_x = pos_x + 1'b1; end
         HD_S: begin at_wall = (pos_y == Y_LIM); tgt_y = pos_y + 1'b1; end
         HD_W: begin at_wall = (pos_x == '0);    tgt_x = pos_x - 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         prev     <= '0;
         pend_v   <= 1'b0;
         pend_cmd <= CMD_FWD;
         blocked  <= 1'b0;
      end else begin
         prev    <= {signalStraight, signalLeft, signalRight};
         blocked <= consume && (pend_cmd == CMD_FWD) && at_wall;
         // the slot frees on the same edge it is consumed, so a fresh edge can refill it
         if ((|in_edge) && (!pend_v || consume)) begin
            pend_v   <= 1'b1;
            pend_cmd <= edge_cmd;
         end else if (consume) begin
            pend_v <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state   <= ST_IDLE;
         heading <= HD_N;
         pos_x   <= X_INIT;
         pos_y   <= Y_INIT;
      end else begin
         case (state)
            ST_IDLE: begin
               if (consume) begin
                  case (pend_cmd)
                     CMD_LEFT:  heading <= heading - 2'd1;
                     CMD_RIGHT: heading <= heading + 2'd1;
                     default:   if (!at_wall) state <= ST_ERASE;
                  endcase
               end
            end
            ST_ERASE: if (draw_bus.draw_ack) state <= ST_MOVE;
            ST_MOVE: begin
               pos_x <= tgt_x;
               pos_y <= tgt_y;
               state <= ST_DRAW;
            end
            ST_DRAW: if (draw_bus.draw_ack) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // request coordinates track pos: old cell during ERASE, new cell during DRAW
   assign draw_bus.draw_req   = (state == ST_ERASE) || (state == ST_DRAW);
   assign draw_bus.draw_erase = (state == ST_ERASE);
   assign draw_bus.draw_x     = pos_x;
   assign draw_bus.draw_y     = pos_y;
   assign busy                = (state != ST_IDLE);

endmodule

// File: tb/tb_kart_nav_ctrl.sv
// Directed bench for kart_nav_ctrl: move handshake, turns, priority, wall clamp, stall, async reset.
module tb_kart_nav_ctrl;
   localparam int XW = 8;
   localparam int YW = 7;

   logic          CLOCK_50 = 1'b0;
   logic          Resetn;
   logic          signalStraight, signalLeft, signalRight;
   logic [XW-1:0] pos_x;
   logic [YW-1:0] pos_y;
   logic [1:0]    heading;
   logic          busy, blocked;

   int checks   = 0;
   int failures = 0;

   kart_nav_if #(.XW(XW), .YW(YW)) nav_if ();

   kart_nav_ctrl #(
      .X_MAX(159), .Y_MAX(119), .X_START(80), .Y_START(60), .XW(XW), .YW(YW)
   ) dut (
      .CLOCK_50       (CLOCK_50),
      .Resetn         (Resetn),
      .signalStraight (signalStraight),
      .signalLeft     (signalLeft),
      .signalRight    (signalRight),
      .draw_bus       (nav_if.master),
      .pos_x          (pos_x),
      .pos_y          (pos_y),
      .heading        (heading),
      .busy           (busy),
      .blocked        (blocked)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // one-cycle pulse: edge captured at the first tick, command acted on at the second
   task automatic pulse(input int which);
      if (which == 0) signalStraight = 1'b1;
      if (which == 1) signalLeft     = 1'b1;
      if (which == 2) signalRight    = 1'b1;
      tick();
      signalStraight = 1'b0;
      signalLeft     = 1'b0;
      signalRight    = 1'b0;
      tick();
   endtask

   task automatic move_fwd();
      pulse(0);
      tick();
      tick();
      tick();
   endtask

   initial begin
      Resetn         = 1'b0;
      signalStraight = 1'b0;
      signalLeft     = 1'b0;
      signalRight    = 1'b0;
      nav_if.draw_ack = 1'b1;
      #25 Resetn = 1'b1;
      #3;

      chk("rst_req", nav_if.draw_req, 0);
      chk("rst_erase", nav_if.draw_erase, 0);
      chk("rst_busy", busy, 0);
      chk("rst_blocked", blocked, 0);
      chk("rst_pos_x", pos_x, 80);
      chk("rst_pos_y", pos_y, 60);
      chk("rst_draw_x", nav_if.draw_x, 80);
      chk("rst_draw_y", nav_if.draw_y, 60);
      chk("rst_heading", heading, 0);

      // forward move with ack tied high
      tick();
      signalStraight = 1'b1;
      tick();
      chk("t1_k_req", nav_if.draw_req, 0);
      chk("t1_k_busy", busy, 0);
      tick();
      chk("t1_erase_req", nav_if.draw_req, 1);
      chk("t1_erase_flag", nav_if.draw_erase, 1);
      chk("t1_erase_x", nav_if.draw_x, 80);
      chk("t1_erase_y", nav_if.draw_y, 60);
      chk("t1_erase_busy", busy, 1);
      tick();
      chk("t1_move_req", nav_if.draw_req, 0);
      chk("t1_move_busy", busy, 1);
      tick();
      chk("t1_draw_req", nav_if.draw_req, 1);
      chk("t1_draw_flag", nav_if.draw_erase, 0);
      chk("t1_draw_x", nav_if.draw_x, 80);
      chk("t1_draw_y", nav_if.draw_y, 59);
      chk("t1_draw_busy", busy, 1);
      tick();
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_req", nav_if.draw_req, 0);
      chk("t1_pos_y", pos_y, 59);
      chk("t1_heading", heading, 0);
      // level held high must not repeat the command
      tick();
      tick();
      chk("t1_hold_busy", busy, 0);
      chk("t1_hold_pos_y", pos_y, 59);
      signalStraight = 1'b0;
      tick();

      // turns
      pulse(2);
      chk("t2_right1", heading, 1);
      chk("t2_right1_req", nav_if.draw_req, 0);
      pulse(2);
      chk("t2_right2", heading, 2);
      pulse(1);
      chk("t2_left", heading, 1);
      chk("t2_left_busy", busy, 0);
      move_fwd();
      chk("t2_pos_x", pos_x, 81);
      chk("t2_pos_y", pos_y, 59);

      // simultaneous edges: only straight runs, the rest are dropped
      signalStraight = 1'b1;
      signalLeft     = 1'b1;
      signalRight    = 1'b1;
      tick();
      signalStraight = 1'b0;
      signalLeft     = 1'b0;
      signalRight    = 1'b0;
      tick();
      chk("t3_erase_req", nav_if.draw_req, 1);
      chk("t3_heading_early", heading, 1);
      tick();
      tick();
      tick();
      tick();
      tick();
      chk("t3_pos_x", pos_x, 82);
      chk("t3_pos_y", pos_y, 59);
      chk("t3_heading", heading, 1);
      chk("t3_busy", busy, 0);

      // walk north to the wall
      pulse(1);
      chk("t4_heading_n", heading, 0);
      for (int i = 0; i < 59; i++) move_fwd();
      chk("t4_wall_y", pos_y, 0);
      chk("t4_wall_x", pos_x, 82);
      signalStraight = 1'b1;
      tick();
      signalStraight = 1'b0;
      tick();
      chk("t4_blocked", blocked, 1);
      chk("t4_blk_req", nav_if.draw_req, 0);
      chk("t4_blk_busy", busy, 0);
      tick();
      chk("t4_blocked_drop", blocked, 0);
      chk("t4_blk_req2", nav_if.draw_req, 0);
      chk("t4_stay_y", pos_y, 0);
      chk("t4_stay_x", pos_x, 82);

      // stalled erase with a left turn queued during the stall
      pulse(2);
      pulse(2);
      chk("t5_heading_s", heading, 2);
      nav_if.draw_ack = 1'b0;
      pulse(0);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) signalLeft = 1'b1;
         if (i == 4) signalLeft = 1'b0;
         tick();
         chk("t5_stall_req", nav_if.draw_req, 1);
         chk("t5_stall_erase", nav_if.draw_erase, 1);
         chk("t5_stall_x", nav_if.draw_x, 82);
         chk("t5_stall_y", nav_if.draw_y, 0);
      end
      chk("t5_stall_heading", heading, 2);
      nav_if.draw_ack = 1'b1;
      tick();
      chk("t5_move_req", nav_if.draw_req, 0);
      tick();
      chk("t5_draw_req", nav_if.draw_req, 1);
      chk("t5_draw_y", nav_if.draw_y, 1);
      tick();
      chk("t5_idle_busy", busy, 0);
      chk("t5_idle_heading", heading, 2);
      tick();
      chk("t5_left_applied", heading, 1);

      // reset while in DRAW
      nav_if.draw_ack = 1'b0;
      pulse(0);
      chk("t6_erase_req", nav_if.draw_req, 1);
      nav_if.draw_ack = 1'b1;
      tick();
      nav_if.draw_ack = 1'b0;
      tick();
      chk("t6_draw_req", nav_if.draw_req, 1);
      chk("t6_draw_x", nav_if.draw_x, 83);
      #3 Resetn = 1'b0;
      #1;
      chk("t6_async_req", nav_if.draw_req, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_pos_x", pos_x, 80);
      chk("t6_async_pos_y", pos_y, 60);
      chk("t6_async_heading", heading, 0);
      chk("t6_async_draw_x", nav_if.draw_x, 80);
      @(negedge CLOCK_50);
      Resetn = 1'b1;
      nav_if.draw_ack = 1'b1;
      tick();
      chk("t6_post_busy", busy, 0);
      chk("t6_post_req", nav_if.draw_req, 0);
      tick();
      chk("t6_post_req2", nav_if.draw_req, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
